// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values, dispenser states and product prices
// common to the vending controller and the change dispenser.
package vend_pkg;

    localparam int COIN_5  = 5;
    localparam int COIN_10 = 10;

    localparam int PRICE_A = 15;
    localparam int PRICE_B = 20;
    localparam int PRICE_C = 25;
    localparam int PRICE_D = 35;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_WAIT_ACK,
        ST_DONE
    } disp_state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Request, refill, hopper and status signals of the change dispenser.
// slave is the dispenser side, master is the vending controller / hopper side.
interface change_dispenser_if #(
    parameter int AMT_W = 6,
    parameter int CNT_W = 8
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             refill_valid;
    logic [CNT_W-1:0] refill_10;
    logic [CNT_W-1:0] refill_5;
    logic             eject_10;
    logic             eject_5;
    logic             hopper_ack;
    logic             done;
    logic [AMT_W-1:0] paid;
    logic             err_short;
    logic             err_timeout;
    logic             fault;
    logic [CNT_W-1:0] cnt_10;
    logic [CNT_W-1:0] cnt_5;

    modport slave (
        input  req_valid, req_amount, refill_valid, refill_10, refill_5, hopper_ack,
        output req_ready, eject_10, eject_5, done, paid, err_short, err_timeout,
               fault, cnt_10, cnt_5
    );

    modport master (
        output req_valid, req_amount, refill_valid, refill_10, refill_5, hopper_ack,
        input  req_ready, eject_10, eject_5, done, paid, err_short, err_timeout,
               fault, cnt_10, cnt_5
    );
endinterface

// File: rtl/change_dispenser_coin_inventory.sv
// Two coin counters (index 0 = 10-coins, 1 = 5-coins) with saturating refill
// and single-coin decrement; refill and decrement are never requested together.
module coin_inventory #(
    parameter int CNT_W   = 8,
    parameter int INIT_10 = 8,
    parameter int INIT_5  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             refill_en,
    input  logic [CNT_W-1:0] refill_10,
    input  logic [CNT_W-1:0] refill_5,
    input  logic             dec_10,
    input  logic             dec_5,
    output logic [CNT_W-1:0] cnt_10,
    output logic [CNT_W-1:0] cnt_5
);
    logic [1:0][CNT_W-1:0] add_amt;
    logic [1:0]            dec;
    logic [1:0][CNT_W-1:0] cnt_all;

    assign add_amt = {refill_5, refill_10};
    assign dec     = {dec_5, dec_10};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        localparam int INIT_VAL = (gi == 0) ? INIT_10 : INIT_5;

        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W:0]   sum;

        always_comb begin
            sum   = {1'b0, cnt_q} + {1'b0, add_amt[gi]};
            cnt_d = cnt_q;
            if (refill_en) begin
                cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            end else if (dec[gi] && (cnt_q != '0)) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= CNT_W'(INIT_VAL);
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_all[gi] = cnt_q;
    end

    assign cnt_10 = cnt_all[0];
    assign cnt_5  = cnt_all[1];
endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount out of a 10/5 coin hopper one coin at a time, largest
// coin first, with a per-coin ack timeout and a sticky fault flag.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 6,
    parameter int CNT_W       = 8,
    parameter int INIT_10     = 8,
    parameter int INIT_5      = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    change_dispenser_if.slave bus
);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AMT_W-1:0] AMT_10 = AMT_W'(COIN_10);
    localparam logic [AMT_W-1:0] AMT_5  = AMT_W'(COIN_5);

    disp_state_e      state_q;
    logic [AMT_W-1:0] remaining_q;
    logic [AMT_W-1:0] paid_q;
    logic             coin_is_10_q;
    logic [TMR_W-1:0] timer_q;
    logic             eject_10_q;
    logic             eject_5_q;
    logic             done_q;
    logic             err_short_q;
    logic             err_timeout_q;
    logic             fault_q;

    logic [AMT_W-1:0] coin_amt;
    logic [CNT_W-1:0] cnt_10;
    logic [CNT_W-1:0] cnt_5;
    logic             ack_take;
    logic             refill_en;

    assign coin_amt  = coin_is_10_q ? AMT_10 : AMT_5;
    assign ack_take  = (state_q == ST_WAIT_ACK) && bus.hopper_ack;
    assign refill_en = (state_q == ST_IDLE) && bus.refill_valid;

    coin_inventory #(
        .CNT_W   (CNT_W),
        .INIT_10 (INIT_10),
        .INIT_5  (INIT_5)
    ) u_inventory (
        .clk       (clk),
        .rst       (rst),
        .refill_en (refill_en),
        .refill_10 (bus.refill_10),
        .refill_5  (bus.refill_5),
        .dec_10    (ack_take && coin_is_10_q),
        .dec_5     (ack_take && !coin_is_10_q),
        .cnt_10    (cnt_10),
        .cnt_5     (cnt_5)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            remaining_q   <= '0;
            paid_q        <= '0;
            coin_is_10_q  <= 1'b0;
            timer_q       <= '0;
            eject_10_q    <= 1'b0;
            eject_5_q     <= 1'b0;
            done_q        <= 1'b0;
            err_short_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            eject_10_q <= 1'b0;
            eject_5_q  <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        remaining_q   <= bus.req_amount;
                        paid_q        <= '0;
                        err_short_q   <= 1'b0;
                        err_timeout_q <= 1'b0;
                        state_q       <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if ((remaining_q >= AMT_10) && (cnt_10 != '0)) begin
                        coin_is_10_q <= 1'b1;
                        eject_10_q   <= 1'b1;
                        state_q      <= ST_EJECT;
                    end else if ((remaining_q >= AMT_5) && (cnt_5 != '0)) begin
                        coin_is_10_q <= 1'b0;
                        eject_5_q    <= 1'b1;
                        state_q      <= ST_EJECT;
                    end else begin
                        // Leftover that no available coin can cover is a shortfall.
                        err_short_q <= (remaining_q != '0);
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_EJECT: begin
                    // timer holds cycles elapsed since the eject pulse
                    timer_q <= TMR_W'(1);
                    state_q <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack_take) begin
                        remaining_q <= remaining_q - coin_amt;
                        paid_q      <= paid_q + coin_amt;
                        state_q     <= ST_SELECT;
                    end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                        err_timeout_q <= 1'b1;
                        fault_q       <= 1'b1;
                        done_q        <= 1'b1;
                        state_q       <= ST_DONE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.eject_10    = eject_10_q;
    assign bus.eject_5     = eject_5_q;
    assign bus.done        = done_q;
    assign bus.paid        = paid_q;
    assign bus.err_short   = err_short_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.fault       = fault_q;
    assign bus.cnt_10      = cnt_10;
    assign bus.cnt_5       = cnt_5;
endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model queues the
// expected outcome per request, checked when done pulses.
`timescale 1ns/1ps
module tb_change_dispenser;

    typedef struct {
        int paid;
        int short_f;
        int tmo;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    change_dispenser_if #(.AMT_W(6), .CNT_W(8)) bus ();

    change_dispenser #(
        .AMT_W       (6),
        .CNT_W       (8),
        .INIT_10     (8),
        .INIT_5      (8),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    done_cnt = 0;
    int    acc_cyc, done_cyc, first_eject_cyc, last_eject_cyc;
    int    mdl_10 = 8;
    int    mdl_5  = 8;
    bit    ack_en = 1'b1;
    int    ack_dly = 2;
    sb_t   sb[$];
    sb_t   exp_e;
    sb_t   got_e;
    int    exp_coins[$];
    int    eject_log[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Hopper model: acks each eject after ack_dly cycles when enabled.
    initial begin
        bus.hopper_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && ack_en && (bus.eject_10 || bus.eject_5)) begin
                repeat (ack_dly) @(posedge clk);
                #1 bus.hopper_ack = 1'b1;
                @(posedge clk);
                #1 bus.hopper_ack = 1'b0;
            end
        end
    end

    // Output monitor: logs ejects and scores each done pulse against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.eject_10 && bus.eject_5) chk("eject_onehot", 2, 1);
            if (bus.eject_10 || bus.eject_5) begin
                if (eject_log.size() == 0) first_eject_cyc = cyc;
                last_eject_cyc = cyc;
                eject_log.push_back(bus.eject_10 ? 10 : 5);
            end
            if (bus.done) begin
                done_cyc = cyc;
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    got_e = sb.pop_front();
                    chk("paid", int'(bus.paid), got_e.paid);
                    chk("err_short", int'(bus.err_short), got_e.short_f);
                    chk("err_timeout", int'(bus.err_timeout), got_e.tmo);
                end
            end
        end
    end

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Greedy reference: largest coin first while inventory lasts.
    task automatic build_expect(input int amt);
        int rem;
        int coin;
        rem = amt;
        exp_coins.delete();
        exp_e.paid = 0;
        exp_e.short_f = 0;
        exp_e.tmo = 0;
        forever begin
            coin = 0;
            if (rem >= 10 && mdl_10 > 0) coin = 10;
            else if (rem >= 5 && mdl_5 > 0) coin = 5;
            if (coin == 0) begin
                exp_e.short_f = (rem != 0) ? 1 : 0;
                break;
            end
            exp_coins.push_back(coin);
            if (!ack_en) begin
                exp_e.tmo = 1;
                break;
            end
            if (coin == 10) mdl_10--; else mdl_5--;
            rem -= coin;
            exp_e.paid += coin;
        end
    endtask

    task automatic do_req(input int amt, input int r_valid, input int r10, input int r5);
        int n0;
        if (r_valid != 0) begin
            mdl_10 = sat8(mdl_10 + r10);
            mdl_5  = sat8(mdl_5 + r5);
        end
        build_expect(amt);
        sb.push_back(exp_e);
        eject_log.delete();
        @(posedge clk);
        #1;
        chk("req_ready", int'(bus.req_ready), 1);
        bus.req_valid    = 1'b1;
        bus.req_amount   = 6'(amt);
        bus.refill_valid = (r_valid != 0);
        bus.refill_10    = 8'(r10);
        bus.refill_5     = 8'(r5);
        n0 = done_cnt;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.req_valid    = 1'b0;
        bus.refill_valid = 1'b0;
        for (int i = 0; i < 2000 && done_cnt == n0; i++) @(posedge clk);
        #1;
        chk("done_seen", done_cnt - n0, 1);
        chk("n_coins", eject_log.size(), exp_coins.size());
        for (int i = 0; i < exp_coins.size() && i < eject_log.size(); i++)
            chk("coin", eject_log[i], exp_coins[i]);
        chk("cnt_10", int'(bus.cnt_10), mdl_10);
        chk("cnt_5", int'(bus.cnt_5), mdl_5);
        $display("[TB] req %0d: paid %0d short %0d tmo %0d coins %0d", amt,
                 exp_e.paid, exp_e.short_f, exp_e.tmo, eject_log.size());
    endtask

    task automatic do_refill(input int r10, input int r5);
        mdl_10 = sat8(mdl_10 + r10);
        mdl_5  = sat8(mdl_5 + r5);
        @(posedge clk);
        #1;
        bus.refill_valid = 1'b1;
        bus.refill_10    = 8'(r10);
        bus.refill_5     = 8'(r5);
        @(posedge clk);
        #1;
        bus.refill_valid = 1'b0;
        chk("refill_cnt_10", int'(bus.cnt_10), mdl_10);
        chk("refill_cnt_5", int'(bus.cnt_5), mdl_5);
        $display("[TB] refill %0d/%0d -> cnt %0d/%0d", r10, r5, mdl_10, mdl_5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bus.req_valid    = 1'b0;
        bus.req_amount   = '0;
        bus.refill_valid = 1'b0;
        bus.refill_10    = '0;
        bus.refill_5     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_ready", int'(bus.req_ready), 1);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_eject", int'(bus.eject_10) + int'(bus.eject_5), 0);
        chk("rst_paid", int'(bus.paid), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_cnt_10", int'(bus.cnt_10), 8);
        chk("rst_cnt_5", int'(bus.cnt_5), 8);
        $display("[TB] reset state checked");

        // 15 -> 10 then 5; first eject on the second edge after acceptance
        do_req(15, 0, 0, 0);
        chk("first_eject_lat", first_eject_cyc - acc_cyc, 1);

        // drain to 0 tens / 2 fives, then a request the fives cannot cover
        do_req(63, 0, 0, 0);
        do_req(15, 0, 0, 0);
        do_req(20, 0, 0, 0);
        do_req(15, 0, 0, 0);

        // non-multiple of 5
        do_refill(0, 3);
        do_req(7, 0, 0, 0);

        // hopper never acks: done 15 cycles after the eject pulse
        do_refill(4, 0);
        ack_en = 1'b0;
        do_req(10, 0, 0, 0);
        chk("tmo_latency", done_cyc - last_eject_cyc, 15);
        chk("fault_set", int'(bus.fault), 1);
        chk("err_timeout_hold", int'(bus.err_timeout), 1);
        ack_en = 1'b1;

        // refill with a zero request in the same cycle; 10-coins saturate
        do_req(0, 1, 255, 0);
        chk("zero_latency", done_cyc - acc_cyc, 1);
        chk("fault_sticky", int'(bus.fault), 1);

        // refill during WAIT_ACK is dropped
        ack_dly = 6;
        fork
            do_req(10, 0, 0, 0);
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("busy_at_refill", int'(bus.req_ready), 0);
                bus.refill_valid = 1'b1;
                bus.refill_10    = 8'd5;
                bus.refill_5     = 8'd5;
                @(posedge clk);
                #1 bus.refill_valid = 1'b0;
            end
        join

        // reset mid-transaction during the first WAIT_ACK
        ack_dly = 8;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b1;
        bus.req_amount = 6'd20;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n0 = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_busy", int'(bus.req_ready), 0);
        rst = 1'b1;
        #1;
        chk("abort_ready", int'(bus.req_ready), 1);
        chk("abort_eject", int'(bus.eject_10) + int'(bus.eject_5), 0);
        chk("abort_fault", int'(bus.fault), 0);
        chk("abort_paid", int'(bus.paid), 0);
        chk("abort_cnt_10", int'(bus.cnt_10), 8);
        chk("abort_cnt_5", int'(bus.cnt_5), 8);
        @(posedge clk);
        #1 rst = 1'b0;
        mdl_10 = 8;
        mdl_5  = 8;
        repeat (20) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_cnt - n0, 0);
        chk("idle_after_rst", int'(bus.req_ready), 1);
        $display("[TB] reset abort checked");

        // normal operation resumes from the reloaded inventory
        ack_dly = 2;
        do_req(25, 0, 0, 0);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Payout-side partner of the 4-product vending controller.
- Accepts a change amount, in units of 1 currency step, over a valid/ready request.
- Pays the amount out by driving a two-denomination coin hopper (10 and 5) one coin at a time, with an eject/ack handshake per coin.
- Tracks the coin inventory, reports amount paid, and flags shortfall and hopper timeout.

Parameters:
- AMT_W, 6, width of request amount and paid amount.
- CNT_W, 8, width of each coin inventory counter.
- INIT_10, 8, number of 10-coins loaded at reset.
- INIT_5, 8, number of 5-coins loaded at reset.
- ACK_TIMEOUT, 15, maximum wait cycles for hopper_ack after an eject pulse.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous, active-high reset.
- req_valid, input, 1, change request present.
- req_amount, input, AMT_W, change to pay.
- req_ready, output, 1, high only in IDLE.
- refill_valid, input, 1, inventory add strobe.
- refill_10, input, CNT_W, 10-coins to add.
- refill_5, input, CNT_W, 5-coins to add.
- eject_10, output, 1, one-cycle pulse: eject one 10-coin.
- eject_5, output, 1, one-cycle pulse: eject one 5-coin.
- hopper_ack, input, 1, hopper confirms the coin left.
- done, output, 1, one-cycle pulse: transaction finished.
- paid, output, AMT_W, total paid; valid while done is high.
- err_short, output, 1, valid with done: paid < requested.
- err_timeout, output, 1, valid with done: hopper did not ack.
- fault, output, 1, sticky after any timeout until rst.
- cnt_10, output, CNT_W, current 10-coin inventory.
- cnt_5, output, CNT_W, current 5-coin inventory.

Behaviour:
- Reset state: IDLE, all pulses 0, paid 0, fault 0, cnt_10=INIT_10, cnt_5=INIT_5, remaining 0, timer 0.
- All outputs are registered or decoded from state only, with no input-to-output combinational path.
- States: IDLE, SELECT, EJECT, WAIT_ACK, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch remaining=req_amount, clear paid and error flags, go to SELECT.
  - If fault=1, requests are still accepted, but a timeout outcome is probable.
- SELECT: evaluate in priority order.
  - remaining>=10 and cnt_10>0: coin=10, go to EJECT.
  - else remaining>=5 and cnt_5>0: coin=5, go to EJECT.
  - else remaining==0: go to DONE, err_short=0.
  - else: go to DONE, err_short=1. This covers non-multiple-of-5 remainders and empty inventory.
- EJECT:
  - Exactly one of eject_10/eject_5 is high for this single cycle.
  - Clear timer, go to WAIT_ACK.
- WAIT_ACK:
  - On hopper_ack: decrement the matching counter, remaining -= coin, paid += coin, go to SELECT.
  - Otherwise timer increments. When timer==ACK_TIMEOUT without ack: err_timeout=1, fault=1, go to DONE.
  - On timeout the inventory and paid values are not updated for the unacked coin.
- DONE:
  - done=1 for one cycle, with paid, err_short and err_timeout held stable during it.
  - Next state is IDLE. Flags keep their values until the next request is accepted.
- hopper_ack outside WAIT_ACK is ignored.
- Refill:
  - Applied only when refill_valid and state==IDLE. Ignored in any other state; no queuing.
  - Each counter saturates at 2^CNT_W-1.
- Refill and req_valid in the same IDLE cycle: both are taken. SELECT then sees the updated counts.
- Latency:
  - Request accepted at edge N: state is SELECT in cycle N+1.
  - First eject pulse appears in cycle N+2.
  - Each coin costs 3 cycles plus the ack delay.
  - A zero request gives done in cycle N+2.
- Arithmetic: remaining and paid are AMT_W wide. paid never exceeds req_amount, and remaining never underflows because the SELECT guards prevent it.
- rst mid-transaction: immediate abort. Eject pulses drop, inventory reloads to INIT values, fault clears.

Decomposition:
- Shared package vend_pkg holds:
  - coin value constants COIN_5=5 and COIN_10=10;
  - the dispenser state enum;
  - product price constants, shared with the vending controller.
- One natural sub-module: coin_inventory. It holds the two saturating counters with refill and decrement ports, and is instantiated once.

Test Plan:
- Reset defaults, req_amount=15, ack 2 cycles after each eject -> eject_10, then eject_5; done with paid=15, err_short=0; cnt_10=7, cnt_5=7.
- Preload via reset INIT_10=0, INIT_5=2, req_amount=15 -> two eject_5 pulses; done with paid=10, err_short=1; cnt_5=0.
- req_amount=7 -> one eject_5; done with paid=5, err_short=1.
- req_amount=10, hopper_ack never asserted -> done 15 cycles after the eject_10 pulse (ACK_TIMEOUT=15); err_timeout=1, fault=1, paid=0, cnt_10 unchanged.
- In IDLE, refill_valid with refill_10=255, together with req_valid, req_amount=0 -> cnt_10 saturates at 255; done 2 cycles after acceptance with paid=0. During the next request's WAIT_ACK, a second refill_valid is ignored.
- req_amount=20, assert rst during the first WAIT_ACK -> all outputs return to reset values, no done pulse, cnt_10=INIT_10.
